// File: rtl/twiddle_addr_gen_pkg.sv
// Shared FFT sequencing helpers: FSM state type, tag field widths and the
// twiddle index mapping also used by the butterfly address generator.
package twiddle_addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DRAIN
  } state_t;

  function automatic int unsigned log2n_of(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned stage_w(input int unsigned n);
    return $clog2($clog2(n)) + 1;
  endfunction

  function automatic int unsigned bfly_w(input int unsigned n);
    return $clog2(n) - 1;
  endfunction

  // Stage s uses the low s bits of j, scaled so every stage addresses the same N/2-entry ROM.
  function automatic int unsigned twiddle_index(input int unsigned log2n,
                                                input int unsigned s,
                                                input int unsigned j);
    return (j & ((32'd1 << s) - 32'd1)) << (log2n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/twiddle_addr_gen_if.sv
// Twiddle sequencer bus: start request in, ROM address and aligned tags out.
// Master is the sequencer; slave is the consumer that pulses start.
interface twiddle_addr_gen_if #(
  parameter int N = 16
) ();
  import twiddle_addr_gen_pkg::*;

  localparam int ADDR_W  = log2n_of(N);
  localparam int STAGE_W = stage_w(N);
  localparam int BFLY_W  = bfly_w(N);

  logic               start;
  logic [ADDR_W-1:0]  rom_addr;
  logic               busy;
  logic               tw_valid;
  logic [STAGE_W-1:0] tw_stage;
  logic [BFLY_W-1:0]  tw_bfly;
  logic               tw_last;
  logic               done;

  modport master (
    input  start,
    output rom_addr, busy, tw_valid, tw_stage, tw_bfly, tw_last, done
  );

  modport slave (
    output start,
    input  rom_addr, busy, tw_valid, tw_stage, tw_bfly, tw_last, done
  );

endinterface

// File: rtl/twiddle_addr_gen_tag_delay_line.sv
// Fixed-depth shift register with async clear; output is input delayed DEPTH cycles.
// No stall input: it advances every cycle.
module tag_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM read sequencer: one address per cycle over all stages, tags delayed
// ROM_LATENCY cycles to line up with ROM data; start is only accepted while idle.
module twiddle_addr_gen
  import twiddle_addr_gen_pkg::*;
#(
  parameter int N           = 16,
  parameter int ROM_LATENCY = 2,
  parameter int STAGE_GAP   = 2
) (
  input  logic               clk,
  input  logic               rst,
  twiddle_addr_gen_if.master bus
);

  localparam int LOG2N   = $clog2(N);
  localparam int ADDR_W  = LOG2N;
  localparam int STAGE_W = stage_w(N);
  localparam int BFLY_W  = bfly_w(N);
  localparam int GAP_W   = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int TAG_W   = 1 + STAGE_W + BFLY_W + 1;

  localparam logic [BFLY_W-1:0]  J_LAST = BFLY_W'(N / 2 - 1);
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [GAP_W-1:0]   G_LAST = GAP_W'(STAGE_GAP - 1);

  state_t             state, state_nxt;
  logic [STAGE_W-1:0] s, s_nxt;
  logic [BFLY_W-1:0]  j, j_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [ADDR_W-1:0]  addr, addr_nxt;

  logic               issue_valid;
  logic               issue_last;
  logic [TAG_W-1:0]   tag_in;
  logic [TAG_W-1:0]   tag_out;
  logic               head_valid;
  logic [STAGE_W-1:0] head_stage;
  logic [BFLY_W-1:0]  head_bfly;
  logic               head_last;
  logic               done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      j       <= '0;
      gap_cnt <= '0;
      addr    <= '0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      j       <= j_nxt;
      gap_cnt <= gap_cnt_nxt;
      addr    <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    s_nxt       = s;
    j_nxt       = j;
    gap_cnt_nxt = gap_cnt;
    addr_nxt    = addr;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          j_nxt     = '0;
          addr_nxt  = ADDR_W'(twiddle_index(LOG2N, 0, 0));
        end
      end
      RUN: begin
        if (j != J_LAST) begin
          j_nxt    = j + 1'b1;
          addr_nxt = ADDR_W'(twiddle_index(LOG2N, 32'(s), 32'(j_nxt)));
        end else if (s != S_LAST) begin
          j_nxt = '0;
          if (STAGE_GAP == 0) begin
            s_nxt    = s + 1'b1;
            addr_nxt = ADDR_W'(twiddle_index(LOG2N, 32'(s_nxt), 0));
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
          end
        end else begin
          state_nxt = DRAIN;
        end
      end
      GAP: begin
        // rom_addr deliberately holds through the gap; only the tag valid drops.
        if (gap_cnt == G_LAST) begin
          state_nxt = RUN;
          s_nxt     = s + 1'b1;
          addr_nxt  = ADDR_W'(twiddle_index(LOG2N, 32'(s_nxt), 0));
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      DRAIN: begin
        // The final tag is at the head when done fires, so the line is empty after this edge.
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign issue_valid = (state == RUN);
  assign issue_last  = (j == J_LAST);
  assign tag_in      = issue_valid ? {1'b1, s, j, issue_last} : '0;

  tag_delay_line #(
    .DEPTH (ROM_LATENCY),
    .WIDTH (TAG_W)
  ) u_tags (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign {head_valid, head_stage, head_bfly, head_last} = tag_out;
  assign done = head_valid & head_last & (head_stage == S_LAST);

  assign bus.rom_addr = addr;
  assign bus.busy     = (state != IDLE);
  assign bus.tw_valid = head_valid;
  assign bus.tw_stage = head_stage;
  assign bus.tw_bfly  = head_bfly;
  assign bus.tw_last  = head_last;
  assign bus.done     = done;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Directed bench for twiddle_addr_gen (N=8): gap-2 and gap-0 instances, scoreboarded tags
// checked against a bench-side 2-cycle ROM model of rom_addr.
module tb_twiddle_addr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twiddle_addr_gen_if #(.N(8)) a_if ();
  twiddle_addr_gen_if #(.N(8)) b_if ();

  twiddle_addr_gen #(.N(8), .ROM_LATENCY(2), .STAGE_GAP(2)) u_a (
    .clk (clk), .rst (rst), .bus (a_if.master)
  );
  twiddle_addr_gen #(.N(8), .ROM_LATENCY(2), .STAGE_GAP(0)) u_b (
    .clk (clk), .rst (rst), .bus (b_if.master)
  );

  typedef struct {
    logic [2:0] addr;
    logic [2:0] stage;
    logic [1:0] bfly;
    logic       last;
    logic       done;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  int addr_tab [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0] a_d1, a_d2, b_d1, b_d2;
  int a_valid_cnt, a_busy_cnt, a_done_cnt;
  int b_valid_cnt, b_busy_cnt, b_done_cnt, b_first_cyc, b_last_cyc;
  bit a_prev_done, b_prev_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bench ROM model: data for an address shows up two cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_d1 <= '0; a_d2 <= '0; b_d1 <= '0; b_d2 <= '0;
    end else begin
      a_d1 <= a_if.rom_addr; a_d2 <= a_d1;
      b_d1 <= b_if.rom_addr; b_d2 <= b_d1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.busy) a_busy_cnt++;
      if (a_prev_done) check("a_busy_after_done", 32'(a_if.busy), 0);
      a_prev_done = a_if.done;
      if (a_if.done) a_done_cnt++;
      if (a_if.tw_valid) begin
        a_valid_cnt++;
        check("a_sb_nonempty", 32'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check("a_addr",  32'(a_d2),         32'(ea.addr));
          check("a_stage", 32'(a_if.tw_stage), 32'(ea.stage));
          check("a_bfly",  32'(a_if.tw_bfly),  32'(ea.bfly));
          check("a_last",  32'(a_if.tw_last),  32'(ea.last));
          check("a_done",  32'(a_if.done),     32'(ea.done));
        end
      end else begin
        check("a_done_idle", 32'(a_if.done), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_if.busy) b_busy_cnt++;
      if (b_prev_done) check("b_busy_after_done", 32'(b_if.busy), 0);
      b_prev_done = b_if.done;
      if (b_if.done) b_done_cnt++;
      if (b_if.tw_valid) begin
        if (b_valid_cnt == 0) b_first_cyc = cyc;
        b_last_cyc = cyc;
        b_valid_cnt++;
        check("b_sb_nonempty", 32'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check("b_addr",  32'(b_d2),         32'(eb.addr));
          check("b_stage", 32'(b_if.tw_stage), 32'(eb.stage));
          check("b_bfly",  32'(b_if.tw_bfly),  32'(eb.bfly));
          check("b_last",  32'(b_if.tw_last),  32'(eb.last));
          check("b_done",  32'(b_if.done),     32'(eb.done));
        end
      end else begin
        check("b_done_idle", 32'(b_if.done), 0);
      end
    end
  end

  task automatic push_sweep(input bit which);
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      e.addr  = 3'(addr_tab[k]);
      e.stage = 3'(k / 4);
      e.bfly  = 2'(k % 4);
      e.last  = (k % 4 == 3);
      e.done  = (k == 11);
      if (which) qb.push_back(e);
      else       qa.push_back(e);
    end
  endtask

  task automatic clear_counts();
    a_valid_cnt = 0; a_busy_cnt = 0; a_done_cnt = 0; a_prev_done = 1'b0;
    b_valid_cnt = 0; b_busy_cnt = 0; b_done_cnt = 0; b_prev_done = 1'b0;
    b_first_cyc = 0; b_last_cyc = 0;
  endtask

  task automatic pulse_start(input bit which);
    @(posedge clk);
    #1;
    if (which) b_if.start = 1'b1; else a_if.start = 1'b1;
    @(posedge clk);
    #1;
    if (which) b_if.start = 1'b0; else a_if.start = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = which ? b_if.done : a_if.done;
    end
    check(which ? "b_done_timeout" : "a_done_timeout", 32'(seen), 1);
  endtask

  task automatic check_idle(input bit which, input string tag);
    if (which) begin
      check({tag, "_addr"},  32'(b_if.rom_addr), 0);
      check({tag, "_busy"},  32'(b_if.busy),     0);
      check({tag, "_valid"}, 32'(b_if.tw_valid), 0);
      check({tag, "_stage"}, 32'(b_if.tw_stage), 0);
      check({tag, "_bfly"},  32'(b_if.tw_bfly),  0);
      check({tag, "_last"},  32'(b_if.tw_last),  0);
      check({tag, "_done"},  32'(b_if.done),     0);
    end else begin
      check({tag, "_addr"},  32'(a_if.rom_addr), 0);
      check({tag, "_busy"},  32'(a_if.busy),     0);
      check({tag, "_valid"}, 32'(a_if.tw_valid), 0);
      check({tag, "_stage"}, 32'(a_if.tw_stage), 0);
      check({tag, "_bfly"},  32'(a_if.tw_bfly),  0);
      check({tag, "_last"},  32'(a_if.tw_last),  0);
      check({tag, "_done"},  32'(a_if.done),     0);
    end
  endtask

  task automatic check_sweep_a(input string tag);
    check({tag, "_valid_cnt"}, 32'(a_valid_cnt), 12);
    check({tag, "_busy_cnt"},  32'(a_busy_cnt),  18);
    check({tag, "_done_cnt"},  32'(a_done_cnt),  1);
    check({tag, "_sb_empty"},  32'(qa.size()),   0);
    check({tag, "_busy_end"},  32'(a_if.busy),   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    clear_counts();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "a_reset");
    check_idle(1, "b_reset");
    @(negedge clk);
    rst = 1'b0;

    // Sweep 1, with a start pulse landing in the done cycle that must be ignored.
    clear_counts();
    push_sweep(0);
    pulse_start(0);
    wait_done(0, 100);
    a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    repeat (6) @(negedge clk);
    check_sweep_a("a_run1");

    // Sweep 2 from idle, with a stray start during stage 1.
    clear_counts();
    push_sweep(0);
    pulse_start(0);
    repeat (7) @(posedge clk);
    #1;
    check("a_busy_mid", 32'(a_if.busy), 1);
    a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    wait_done(0, 100);
    repeat (4) @(negedge clk);
    check_sweep_a("a_run2");

    // Reset during the stage-1 gap.
    clear_counts();
    push_sweep(0);
    pulse_start(0);
    repeat (10) @(posedge clk);
    #1;
    check("a_pre_rst_busy",  32'(a_if.busy),     1);
    check("a_pre_rst_valid", 32'(a_if.tw_valid), 1);
    check("a_pre_rst_cnt",   32'(a_valid_cnt),   6);
    #1;
    rst = 1'b1;
    #1;
    check_idle(0, "a_rst_async");
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_counts();
    repeat (25) @(negedge clk);
    check("a_post_rst_valid_cnt", 32'(a_valid_cnt), 0);
    check("a_post_rst_busy",      32'(a_if.busy),   0);

    clear_counts();
    push_sweep(0);
    pulse_start(0);
    wait_done(0, 100);
    repeat (4) @(negedge clk);
    check_sweep_a("a_run3");

    // Zero-gap instance: 12 back-to-back valids.
    clear_counts();
    push_sweep(1);
    pulse_start(1);
    wait_done(1, 100);
    repeat (4) @(negedge clk);
    check("b_valid_cnt", 32'(b_valid_cnt), 12);
    check("b_busy_cnt",  32'(b_busy_cnt),  14);
    check("b_done_cnt",  32'(b_done_cnt),  1);
    check("b_span",      32'(b_last_cyc - b_first_cyc), 11);
    check("b_sb_empty",  32'(qb.size()),   0);
    check("b_busy_end",  32'(b_if.busy),   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
